// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and types for the display scanner
//
// Purpose: constants and helper used by disp_scan and disp_tick.
// Contents:
//   ANODE_OFF     all-ones anode pattern (slice to NUM_DIGITS bits)
//   BLANK_SEG     segment pattern the downstream decoder drives when blank=1
//   scan_out_t    registered digit/blank/frame_done output bundle
//   idx_width()   width of the slot index for a given digit count
package disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam logic [6:0]            BLANK_SEG = 7'b1111111;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       frame_done;
  } scan_out_t;

  localparam scan_out_t SCAN_OUT_RST = '{digit: 4'h0, blank: 1'b1, frame_done: 1'b0};

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disp_tick.sv
// rtl/disp_tick.sv - slot prescaler for the display scanner
//
// Purpose: counts 0..REFRESH_DIV-1 per digit slot and flags the dead time.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   slot_tick_o  high in the last cycle of a slot (counter at REFRESH_DIV-1)
//   dead_o       high while the counter is below DEAD_CYCLES
module disp_tick #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic slot_tick_o,
  output logic dead_o
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;

  assign slot_tick_o = (pcnt_q == PW'(REFRESH_DIV - 1));
  assign dead_o      = (pcnt_q < PW'(DEAD_CYCLES));

  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (slot_tick_o) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - time-multiplexed 7-segment digit scanner
//
// Purpose: holds a frame-stable display word, scans its digits one slot at a
// time with dead time at slot start, and drives the digit code, active-low
// anode enables and a blank flag for the downstream segment decoder.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant nonzero digit; digit 0 is always shown).
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   value_in    packed hex digits, digit 0 in bits [3:0]
//   load        one-cycle strobe capturing value_in into the pending word
//   digit_out   digit code for the current slot
//   anode_n     active-low digit enables, at most one bit low
//   blank       high when the current slot shows nothing
//   frame_done  one-cycle pulse after each frame boundary
module disp_scan
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic slot_tick;
  logic dead;
  logic frame_wrap;

  logic [IW-1:0]           idx_q,     idx_d;
  logic [4*NUM_DIGITS-1:0] active_q,  active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_v_q,  pend_v_d;
  scan_out_t               out_q,     out_d;
  logic [NUM_DIGITS-1:0]   anode_q,   anode_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
`endif

  disp_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_tick (
    .clk_i       (clk),
    .rst_i       (rst),
    .slot_tick_o (slot_tick),
    .dead_o      (dead)
  );

  assign frame_wrap = slot_tick && (idx_q == LAST_IDX);

  // Slot index and the active/pending handshake. The pending word is only
  // promoted at the frame wrap, so a frame never mixes two values. A load in
  // the wrap cycle lands in pending after the promotion and waits a frame.
  always_comb begin
    idx_d     = idx_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;

    if (slot_tick) begin
      idx_d = frame_wrap ? '0 : idx_q + IW'(1);
    end

    if (frame_wrap && pend_v_q) begin
      active_d = pending_q;
      pend_v_d = 1'b0;
    end

    if (load) begin
      pending_d = value_in;
      pend_v_d  = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Highest slot holding a nonzero digit; stays 0 for an all-zero word so
  // the rightmost digit still shows "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active_q[4*i +: 4] != 4'h0) begin
        msd = IW'(i);
      end
    end
  end
`endif

  // Outputs are computed from the current state and registered, so a slot
  // change shows up one cycle after it happens in the counters.
  always_comb begin
    out_d            = SCAN_OUT_RST;
    out_d.frame_done = frame_wrap;
    out_d.blank      = dead;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        out_d.digit = active_q[4*i +: 4];
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_q > msd) begin
      out_d.blank = 1'b1;
    end
`endif

    anode_d = ANODE_OFF[NUM_DIGITS-1:0];
    if (!dead) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IW'(i)) begin
          anode_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      out_q     <= SCAN_OUT_RST;
      anode_q   <= ANODE_OFF[NUM_DIGITS-1:0];
    end else begin
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      out_q     <= out_d;
      anode_q   <= anode_d;
    end
  end

  assign digit_out  = out_q.digit;
  assign blank      = out_q.blank;
  assign frame_done = out_q.frame_done;
  assign anode_n    = anode_q;

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed vector bench for disp_scan
module tb_disp_scan;

  logic        clk;
  logic        rst;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_out;
  logic [3:0]  anode_n;
  logic        blank;
  logic        frame_done;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  d;
    logic [3:0]  an;
    logic        bl;
    logic        bl_lz;
    logic        fd;
  } vec_t;

  vec_t tbl[$];

  disp_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .digit_out  (digit_out),
    .anode_n    (anode_n),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int c, input logic ld, input logic [15:0] val,
                     input logic [3:0] d, input logic [3:0] an,
                     input logic bl, input logic bl_lz, input logic fd);
    vec_t v;
    v.cyc = c; v.ld = ld; v.val = val; v.d = d; v.an = an;
    v.bl = bl; v.bl_lz = bl_lz; v.fd = fd;
    tbl.push_back(v);
  endtask

  // One clock edge with the given load strobe; returns at the falling edge.
  task automatic step(input logic ld, input logic [15:0] val);
    load     = ld;
    value_in = val;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    load     = 1'b0;
    value_in = 16'h0000;
  endtask

  task automatic check(input string name, input logic [3:0] d, input logic [3:0] an,
                       input logic bl, input logic bl_lz, input logic fd);
    logic eb;
`ifdef LEADING_ZERO_BLANK_EN
    eb = bl_lz;
`else
    eb = bl;
`endif
    checks++;
    if (digit_out !== d || anode_n !== an || blank !== eb || frame_done !== fd) begin
      errors++;
      $display("FAIL %s cyc=%0d: got digit=%h anode_n=%b blank=%b frame_done=%b, want digit=%h anode_n=%b blank=%b frame_done=%b",
               name, cyc, digit_out, anode_n, blank, frame_done, d, an, eb, fd);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value_in = 16'h0000;

    // cycle, load, value, digit, anode_n, blank, blank(lzb), frame_done
    add(  1, 1, 16'h1234, 4'h0, 4'hF, 1, 1, 0);
    add(  2, 0, 16'h0000, 4'h0, 4'hF, 1, 1, 0);
    add(  3, 0, 16'h0000, 4'h0, 4'hE, 0, 0, 0);
    add(  8, 0, 16'h0000, 4'h0, 4'hE, 0, 0, 0);
    add(  9, 0, 16'h0000, 4'h0, 4'hF, 1, 1, 0);
    add( 11, 0, 16'h0000, 4'h0, 4'hD, 0, 1, 0);
    add( 32, 0, 16'h0000, 4'h0, 4'h7, 0, 1, 1);
    add( 33, 0, 16'h0000, 4'h4, 4'hF, 1, 1, 0);
    add( 35, 0, 16'h0000, 4'h4, 4'hE, 0, 0, 0);
    add( 43, 0, 16'h0000, 4'h3, 4'hD, 0, 0, 0);
    add( 51, 0, 16'h0000, 4'h2, 4'hB, 0, 0, 0);
    add( 59, 0, 16'h0000, 4'h1, 4'h7, 0, 0, 0);
    add( 64, 0, 16'h0000, 4'h1, 4'h7, 0, 0, 1);
    add( 65, 0, 16'h0000, 4'h4, 4'hF, 1, 1, 0);
    // tear-free: ABCD loaded mid-frame
    add( 70, 1, 16'hABCD, 4'h4, 4'hE, 0, 0, 0);
    add( 75, 0, 16'h0000, 4'h3, 4'hD, 0, 0, 0);
    add( 91, 0, 16'h0000, 4'h1, 4'h7, 0, 0, 0);
    add( 96, 0, 16'h0000, 4'h1, 4'h7, 0, 0, 1);
    add( 99, 0, 16'h0000, 4'hD, 4'hE, 0, 0, 0);
    add(107, 0, 16'h0000, 4'hC, 4'hD, 0, 0, 0);
    add(115, 0, 16'h0000, 4'hB, 4'hB, 0, 0, 0);
    add(123, 0, 16'h0000, 4'hA, 4'h7, 0, 0, 0);
    // double load: 2222 wins
    add(130, 1, 16'h1111, 4'hD, 4'hF, 1, 1, 0);
    add(140, 1, 16'h2222, 4'hC, 4'hD, 0, 0, 0);
    add(155, 0, 16'h0000, 4'hA, 4'h7, 0, 0, 0);
    add(160, 0, 16'h0000, 4'hA, 4'h7, 0, 0, 1);
    add(163, 0, 16'h0000, 4'h2, 4'hE, 0, 0, 0);
    add(171, 0, 16'h0000, 4'h2, 4'hD, 0, 0, 0);
    add(187, 0, 16'h0000, 4'h2, 4'h7, 0, 0, 0);
    // load in the boundary cycle waits a full frame
    add(192, 1, 16'h5678, 4'h2, 4'h7, 0, 0, 1);
    add(195, 0, 16'h0000, 4'h2, 4'hE, 0, 0, 0);
    add(227, 0, 16'h0000, 4'h8, 4'hE, 0, 0, 0);
    // leading zeros
    add(230, 1, 16'h0050, 4'h8, 4'hE, 0, 0, 0);
    add(235, 0, 16'h0000, 4'h7, 4'hD, 0, 0, 0);
    add(259, 0, 16'h0000, 4'h0, 4'hE, 0, 0, 0);
    add(267, 0, 16'h0000, 4'h5, 4'hD, 0, 0, 0);
    add(275, 0, 16'h0000, 4'h0, 4'hB, 0, 1, 0);
    add(283, 0, 16'h0000, 4'h0, 4'h7, 0, 1, 0);
    add(290, 1, 16'h0000, 4'h0, 4'hF, 1, 1, 0);
    add(323, 0, 16'h0000, 4'h0, 4'hE, 0, 0, 0);
    add(331, 0, 16'h0000, 4'h0, 4'hD, 0, 1, 0);
    add(347, 0, 16'h0000, 4'h0, 4'h7, 0, 1, 0);
    // set up for the mid-frame reset: 9999 active, 7777 pending
    add(350, 1, 16'h9999, 4'h0, 4'h7, 0, 1, 0);
    add(355, 1, 16'h7777, 4'h9, 4'hE, 0, 0, 0);
    add(363, 0, 16'h0000, 4'h9, 4'hD, 0, 0, 0);

    // reset held for three cycles
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
    end
    rst = 1'b0;
    cyc = 0;

    foreach (tbl[v]) begin
      while (cyc < tbl[v].cyc - 1) step(1'b0, 16'h0000);
      step(tbl[v].ld, tbl[v].val);
      check($sformatf("vec%0d", v), tbl[v].d, tbl[v].an, tbl[v].bl, tbl[v].bl_lz, tbl[v].fd);
    end

    // mid-frame reset in slot 2 with a pending word and a coincident load
    while (cyc < 369) step(1'b0, 16'h0000);
    rst = 1'b1;
    step(1'b1, 16'h4444);
    check("midreset_0", 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000);
    check("midreset_1", 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 3) step(1'b0, 16'h0000);
    check("post_reset_first_anode", 4'h0, 4'hE, 1'b0, 1'b0, 1'b0);
    while (cyc < 32) step(1'b0, 16'h0000);
    check("post_reset_frame_done", 4'h0, 4'h7, 1'b0, 1'b1, 1'b1);
    while (cyc < 35) step(1'b0, 16'h0000);
    check("post_reset_slot0", 4'h0, 4'hE, 1'b0, 1'b0, 1'b0);
    while (cyc < 43) step(1'b0, 16'h0000);
    check("post_reset_slot1", 4'h0, 4'hD, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
# disp_scan

Time-multiplexed scanner for a common-anode multi-digit 7-segment display, sitting directly upstream of the hex-digit-to-segment decoder. Holds a frame-stable copy of a packed multi-digit value. Steps through the digits at a fixed refresh rate and presents one 4-bit digit code per slot to the decoder, together with the matching active-low anode enable and a blank flag. Inserts dead time between slots to suppress ghosting.

## Interface
- NUM_DIGITS, 4, number of display digits (2..8)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ DEAD_CYCLES+2)
- DEAD_CYCLES, 16, cycles at slot start with all anodes off (≥1)
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- value_in  in  4*NUM_DIGITS  packed hex digits; digit 0 = bits [3:0], the rightmost digit
- load  in  1  single-cycle strobe; captures value_in
- digit_out  out  4  digit code to segment decoder
- anode_n  out  NUM_DIGITS  active-low digit enables; at most one bit low
- blank  out  1  high = current slot shows nothing; downstream forces segments to all-off (7'b1111111)
- frame_done  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers:
  - prescaler `pcnt` counts 0..REFRESH_DIV-1; wraps to 0.
  - slot index `idx` counts 0..NUM_DIGITS-1.
  - `active` display word.
  - `pending` word with `pend_v` flag.
- Slot advance: when pcnt = REFRESH_DIV-1, pcnt→0 and idx→idx+1. Wrap from NUM_DIGITS-1 to 0 is the frame boundary.
- Load handshake:
  - load=1 writes value_in into pending and sets pend_v.
  - A load while pend_v=1 overwrites pending; the last load wins.
  - At a frame boundary with pend_v=1, active←pending and pend_v←0.
  - A load in the boundary cycle itself goes to pending and applies at the following boundary.
  - Digits are never torn within a frame.
- Dead time: anode_n is all ones while pcnt < DEAD_CYCLES. Otherwise anode_n is all ones except bit idx low.
- digit_out = active[4*idx+3 : 4*idx] throughout the slot, including dead time.
- blank = 1 during dead time; otherwise 0, except as modified by Configuration.
- frame_done = 1 in the cycle where idx wraps to 0.

## Timing
- Reset values:
  - pcnt=0, idx=0.
  - active=0, pending=0, pend_v=0.
  - digit_out=0, anode_n=all ones, blank=1, frame_done=0.
- All outputs are registered and derived from the state of the previous cycle.
  - A slot change at cycle t appears on the outputs at t+1.
- Slot length is REFRESH_DIV cycles. Frame length is NUM_DIGITS·REFRESH_DIV cycles.
- Load-to-display latency: ≤ frame length + 1 cycle.
- After rst deasserts, the first anode goes low DEAD_CYCLES+1 cycles later, on idx 0.
- rst asserted mid-frame: next cycle returns to the reset values and discards any pending load. A load coincident with rst is ignored.

## Configuration
- LEADING_ZERO_BLANK_EN:
  - Defined: blank is also 1 in any slot whose digit is above the most significant nonzero digit of active. Digit 0 is never blanked this way, so an all-zero value shows a single "0".
  - Undefined: leading zeros are displayed.
  - Blanking is evaluated on active, so it changes only at frame boundaries.

## Structure
- Package disp_pkg:
  - ANODE_OFF constant (all ones).
  - idx width function clog2(NUM_DIGITS).
  - BLANK_SEG constant 7'b1111111 for downstream use.
- One natural sub-module: disp_tick, the prescaler. It outputs a slot_tick and a dead-time flag.
- Digit select and the load/pending logic stay in disp_scan.
- The segment decoder is instantiated by the parent, not by this block.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
- Reset: hold rst 3 cycles → anode_n=4'b1111, blank=1, digit_out=0, frame_done=0. After release, anode_n=4'b1110 from cycle 3 (DEAD_CYCLES+1).
- Scan order: load 16'h1234, wait 2 frames → slots show digit_out 4,3,2,1 with anode_n 1110,1101,1011,0111. Each anode is low 6 cycles, all off 2 cycles. frame_done pulses every 32 cycles.
- Tear-free: load 16'hABCD mid-frame while showing 16'h1234 → remaining slots keep 1234 digits. ABCD first appears in the slot after the next frame_done.
- Double load: load 16'h1111 then 16'h2222 in the same frame → the next frame shows 2222; 1111 is never displayed.
- Leading zeros: with LEADING_ZERO_BLANK_EN, load 16'h0050 → blank=1 in slots 3 and 2, blank=0 in slots 1 and 0. Load 16'h0000 → only slot 0 unblanked. Without the macro → no blanking beyond dead time.
- Mid-operation reset: assert rst in slot 2 with pend_v=1 → reset values next cycle; after release, active=0 and the pending value is lost.
